// File: rtl/food_placer_pkg.sv
// Shared types and default grid geometry for the food placement block.
package food_placer_pkg;

  // Mirrors the game-wide grid dimensions.
  localparam int unsigned DefGridWidth  = 20;
  localparam int unsigned DefGridHeight = 15;

  typedef enum logic [1:0] {
    StIdle,
    StRand,
    StScan
  } state_e;

endpackage

// File: rtl/food_raster_stepper.sv
// Candidate cell register: loads a wrapped random coordinate or steps to the raster successor.
module food_raster_stepper #(
  parameter int unsigned GRID_WIDTH  = 20,
  parameter int unsigned GRID_HEIGHT = 15,
  parameter int unsigned XW          = $clog2(GRID_WIDTH),
  parameter int unsigned YW          = $clog2(GRID_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [XW-1:0] rand_x_i,
  input  logic [YW-1:0] rand_y_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      // Inputs are below twice the dimension, so one subtraction is enough.
      x_d = (32'(rand_x_i) >= GRID_WIDTH)  ? rand_x_i - XW'(GRID_WIDTH)  : rand_x_i;
      y_d = (32'(rand_y_i) >= GRID_HEIGHT) ? rand_y_i - YW'(GRID_HEIGHT) : rand_y_i;
    end else if (advance_i) begin
      if (x_q == XW'(GRID_WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(GRID_HEIGHT - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/food_placer.sv
// Picks a free grid cell for food: bounded random draws, then a full raster scan fallback.
module food_placer
  import food_placer_pkg::*;
#(
  parameter int unsigned GRID_WIDTH  = DefGridWidth,
  parameter int unsigned GRID_HEIGHT = DefGridHeight,
  parameter int unsigned MAX_RETRIES = 8,
  localparam int unsigned XW         = $clog2(GRID_WIDTH),
  localparam int unsigned YW         = $clog2(GRID_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [XW-1:0] rand_x_i,
  input  logic [YW-1:0] rand_y_i,
  output logic          occ_req_o,
  output logic [XW-1:0] occ_x_o,
  output logic [YW-1:0] occ_y_o,
  input  logic          occ_ack_i,
  input  logic          occ_hit_i,
  output logic [XW-1:0] food_x_o,
  output logic [YW-1:0] food_y_o,
  output logic          food_valid_o,
  output logic          busy_o,
  output logic          grid_full_o
);

  localparam int unsigned Cells = GRID_WIDTH * GRID_HEIGHT;
  localparam int unsigned SW    = $clog2(Cells + 1);
  localparam int unsigned RW    = $clog2(MAX_RETRIES + 1);

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [SW-1:0] scan_q, scan_d;
  logic [XW-1:0] food_x_q, food_x_d;
  logic [YW-1:0] food_y_q, food_y_d;
  logic          food_valid_q, food_valid_d;
  logic          grid_full_q, grid_full_d;
  logic          load, advance;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;

  food_raster_stepper #(
    .GRID_WIDTH  (GRID_WIDTH),
    .GRID_HEIGHT (GRID_HEIGHT),
    .XW          (XW),
    .YW          (YW)
  ) u_stepper (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .advance_i (advance),
    .rand_x_i  (rand_x_i),
    .rand_y_i  (rand_y_i),
    .x_o       (cand_x),
    .y_o       (cand_y)
  );

  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    scan_d       = scan_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    grid_full_d  = grid_full_q;
    load         = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          load         = 1'b1;
          food_valid_d = 1'b0;
          grid_full_d  = 1'b0;
          retry_d      = '0;
          state_d      = StRand;
        end
      end
      StRand: begin
        if (occ_ack_i) begin
          if (!occ_hit_i) begin
            food_x_d     = cand_x;
            food_y_d     = cand_y;
            food_valid_d = 1'b1;
            state_d      = StIdle;
          end else begin
            retry_d = retry_inc;
            if (32'(retry_inc) < MAX_RETRIES) begin
              load = 1'b1;
            end else begin
              scan_d  = SW'(1);
              advance = 1'b1;
              state_d = StScan;
            end
          end
        end
      end
      StScan: begin
        if (occ_ack_i) begin
          if (!occ_hit_i) begin
            food_x_d     = cand_x;
            food_y_d     = cand_y;
            food_valid_d = 1'b1;
            state_d      = StIdle;
          end else if (scan_q == SW'(Cells)) begin
            // Every cell has been visited once since the fallback began.
            grid_full_d  = 1'b1;
            food_valid_d = 1'b0;
            state_d      = StIdle;
          end else begin
            scan_d  = scan_q + SW'(1);
            advance = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      retry_q      <= '0;
      scan_q       <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      grid_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      scan_q       <= scan_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      grid_full_q  <= grid_full_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign occ_req_o    = busy_o;
  assign occ_x_o      = cand_x;
  assign occ_y_o      = cand_y;
  assign food_x_o     = food_x_q;
  assign food_y_o     = food_y_q;
  assign food_valid_o = food_valid_q;
  assign grid_full_o  = grid_full_q;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboarded random bench for food_placer on a 4x3 grid with two random retries.
module tb_food_placer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int MR = 2;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic [XW-1:0] rand_x_i = '0;
  logic [YW-1:0] rand_y_i = '0;
  logic          occ_req_o;
  logic [XW-1:0] occ_x_o;
  logic [YW-1:0] occ_y_o;
  logic          occ_ack_i = 1'b0;
  logic          occ_hit_i = 1'b0;
  logic [XW-1:0] food_x_o;
  logic [YW-1:0] food_y_o;
  logic          food_valid_o;
  logic          busy_o;
  logic          grid_full_o;

  food_placer #(
    .GRID_WIDTH  (W),
    .GRID_HEIGHT (H),
    .MAX_RETRIES (MR)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .rand_x_i     (rand_x_i),
    .rand_y_i     (rand_y_i),
    .occ_req_o    (occ_req_o),
    .occ_x_o      (occ_x_o),
    .occ_y_o      (occ_y_o),
    .occ_ack_i    (occ_ack_i),
    .occ_hit_i    (occ_hit_i),
    .food_x_o     (food_x_o),
    .food_y_o     (food_y_o),
    .food_valid_o (food_valid_o),
    .busy_o       (busy_o),
    .grid_full_o  (grid_full_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  bit occ [H][W];
  int seq_x [16];
  int seq_y [16];
  int last_fx = 0;
  int last_fy = 0;
  bit mon_en  = 1'b0;

  // Scoreboard: expected query sequence and expected outcome per placement.
  int qx [$];
  int qy [$];
  int rx [$];
  int ry [$];
  int rv [$];
  int rf [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: try MR wrapped draws, then walk the grid linearly from the last draw.
  task automatic model(output int nq);
    int cx, cy, idx;
    nq = 0;
    cx = 0;
    cy = 0;
    for (int k = 0; k < MR; k++) begin
      cx = seq_x[k] % W;
      cy = seq_y[k] % H;
      qx.push_back(cx); qy.push_back(cy); nq++;
      if (!occ[cy][cx]) begin
        last_fx = cx; last_fy = cy;
        rx.push_back(cx); ry.push_back(cy); rv.push_back(1); rf.push_back(0);
        return;
      end
    end
    idx = cy * W + cx;
    for (int n = 0; n < W * H; n++) begin
      idx = (idx + 1) % (W * H);
      cx = idx % W;
      cy = idx / W;
      qx.push_back(cx); qy.push_back(cy); nq++;
      if (!occ[cy][cx]) begin
        last_fx = cx; last_fy = cy;
        rx.push_back(cx); ry.push_back(cy); rv.push_back(1); rf.push_back(0);
        return;
      end
    end
    rx.push_back(last_fx); ry.push_back(last_fy); rv.push_back(0); rf.push_back(1);
  endtask

  function automatic bit lookup(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (int'(x) < W && int'(y) < H) return occ[y][x];
    return 1'b1;
  endfunction

  task automatic fill_occ(input bit v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) occ[y][x] = v;
  endtask

  task automatic place(input int max_delay, input bit poke);
    int nq, iters, wait_cnt, k;
    model(nq);
    @(posedge clk_i); #1;
    req_i = 1'b1; occ_ack_i = 1'b0;
    rand_x_i = XW'(seq_x[0]); rand_y_i = YW'(seq_y[0]);
    k = 0; iters = 0;
    wait_cnt = $urandom_range(max_delay, 0);
    while (1) begin
      @(posedge clk_i); #1;
      req_i = 1'b0; occ_ack_i = 1'b0; occ_hit_i = 1'($urandom);
      rand_x_i = XW'($urandom); rand_y_i = YW'($urandom);
      iters++;
      if (iters == 1) begin
        check("start_busy", busy_o, 1);
        check("start_full_clear", grid_full_o, 0);
        check("start_valid_clear", food_valid_o, 0);
      end
      if (!busy_o) break;
      if (iters > 300) begin
        check("placement_timeout", iters, 0);
        break;
      end
      if (poke && $urandom_range(3, 0) == 0) req_i = 1'b1;
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        occ_ack_i = 1'b1;
        occ_hit_i = lookup(occ_x_o, occ_y_o);
        if (k < 15) k++;
        rand_x_i = XW'(seq_x[k]); rand_y_i = YW'(seq_y[k]);
        wait_cnt = $urandom_range(max_delay, 0);
      end
    end
    if (max_delay == 0) check("latency_cycles", iters, nq + 1);
  endtask

  // Monitor: compares the presented query every request cycle and the outcome when busy drops.
  initial begin
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!mon_en || !rst_ni) begin
        busy_prev = 1'b0;
      end else begin
        if (occ_req_o) begin
          check("query_expected", qx.size() > 0, 1);
          if (qx.size() > 0) begin
            check("occ_x", occ_x_o, qx[0]);
            check("occ_y", occ_y_o, qy[0]);
            if (occ_ack_i) begin
              void'(qx.pop_front());
              void'(qy.pop_front());
            end
          end
        end
        if (busy_prev && !busy_o) begin
          check("result_expected", rx.size() > 0, 1);
          if (rx.size() > 0) begin
            check("food_x", food_x_o, rx.pop_front());
            check("food_y", food_y_o, ry.pop_front());
            check("food_valid", food_valid_o, rv.pop_front());
            check("grid_full", grid_full_o, rf.pop_front());
            check("occ_req_done", occ_req_o, 0);
          end
        end
        busy_prev = busy_o;
      end
    end
  end

  initial begin
    #23;
    check("rst_occ_req", occ_req_o, 0);
    check("rst_occ_x", occ_x_o, 0);
    check("rst_occ_y", occ_y_o, 0);
    check("rst_food_x", food_x_o, 0);
    check("rst_food_y", food_y_o, 0);
    check("rst_food_valid", food_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_grid_full", grid_full_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("no_self_place", busy_o | food_valid_o, 0);
    mon_en = 1'b1;

    // Free grid, best-case latency.
    fill_occ(1'b0);
    seq_x[0] = 2; seq_y[0] = 1;
    place(0, 1'b0);

    // Row input beyond the grid wraps once.
    seq_x[0] = 1; seq_y[0] = 3;
    place(0, 1'b0);

    // First draw hits, second draw lands on a free cell.
    fill_occ(1'b0);
    occ[1][1] = 1'b1;
    seq_x[0] = 1; seq_y[0] = 1; seq_x[1] = 3; seq_y[1] = 2;
    place(0, 1'b0);

    // Both draws hit, scan resumes after (3,2) and wraps to the origin.
    fill_occ(1'b0);
    occ[1][0] = 1'b1; occ[2][3] = 1'b1; occ[0][0] = 1'b1;
    seq_x[0] = 0; seq_y[0] = 1; seq_x[1] = 3; seq_y[1] = 2;
    place(0, 1'b0);

    // Full grid, then a free grid to show the full flag clears on the next request.
    fill_occ(1'b1);
    seq_x[0] = 2; seq_y[0] = 0; seq_x[1] = 1; seq_y[1] = 2;
    place(0, 1'b0);
    fill_occ(1'b0);
    seq_x[0] = 3; seq_y[0] = 0;
    place(0, 1'b0);

    // Slow acknowledge with requests pulsed while busy.
    fill_occ(1'b0);
    occ[0][1] = 1'b1;
    seq_x[0] = 1; seq_y[0] = 0; seq_x[1] = 2; seq_y[1] = 2;
    place(3, 1'b1);

    // Abandon a pending query with an asynchronous reset.
    @(posedge clk_i); #1;
    mon_en = 1'b0;
    req_i = 1'b1; rand_x_i = 2'd2; rand_y_i = 2'd1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_occ_req", occ_req_o, 1);
      check("wait_occ_x", occ_x_o, 2);
      check("wait_occ_y", occ_y_o, 1);
      rand_x_i = XW'($urandom); rand_y_i = YW'($urandom);
      req_i = (i == 1);
      @(posedge clk_i); #1;
    end
    req_i = 1'b0;
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check("arst_outputs",
          {occ_req_o, occ_x_o, occ_y_o, food_x_o, food_y_o, food_valid_o, busy_o, grid_full_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    last_fx = 0; last_fy = 0;
    mon_en = 1'b1;

    // Random occupancy density, draws and acknowledge delays.
    for (int t = 0; t < 60; t++) begin
      int dens;
      dens = $urandom_range(4, 0);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) occ[y][x] = ($urandom_range(3, 0) < dens);
      for (int k = 0; k < 16; k++) begin
        seq_x[k] = $urandom_range(3, 0);
        seq_y[k] = $urandom_range(3, 0);
      end
      place((t % 3 == 0) ? 0 : 3, t[0]);
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("queries_drained", qx.size(), 0);
    check("results_drained", rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
